zero_byte_unpacker: RTL and testbench

ZERO_BYTE_UNPACKER -- requirements
Module: zero_byte_unpacker

---
 rtl/zero_byte_unpacker.sv | 142 ++++++++++++++
 tb/tb_zero_byte_unpacker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/zero_byte_unpacker.sv
// Zero-byte decompressor: expands up to 32 packed nonzero bytes into a 32-byte word
// under control of a 32-bit bitmap, one output byte per cycle.
module zero_byte_unpacker #(
  parameter bit CHECK_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] packed_bytes,
  input  logic [31:0]  packed_meta,
  output logic [255:0] unpacked,
  output logic [5:0]   nz_count,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned NB = 32;
  localparam int unsigned DW = 8 * NB;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [4:0]    ptr_q, ptr_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          err_acc_q, err_acc_d;
  logic [DW-1:0] work_q, work_d;
  logic [DW-1:0] cap_packed_q, cap_packed_d;
  logic [NB-1:0] cap_meta_q, cap_meta_d;
  logic [DW-1:0] unpacked_q, unpacked_d;
  logic [5:0]    nz_count_q, nz_count_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [7:0]    slot_sel;
  logic          meta_bit;
  logic [7:0]    byte_val;

  // Slot k lives at the MSB end: slot 0 is packed_bytes[255:248].
  always_comb begin
    slot_sel = 8'h00;
    for (int k = 0; k < 32; k++) begin
      if (ptr_q == 5'(k)) slot_sel = cap_packed_q[255 - 8*k -: 8];
    end
  end

  assign meta_bit = cap_meta_q[5'd31 - idx_q];
  assign byte_val = meta_bit ? slot_sel : 8'h00;

  // Next-state and datapath; work word shifts in bytes so byte 0 lands at the MSB end.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    err_acc_d    = err_acc_q;
    work_d       = work_q;
    cap_packed_d = cap_packed_q;
    cap_meta_d   = cap_meta_q;
    unpacked_d   = unpacked_q;
    nz_count_d   = nz_count_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cap_packed_d = packed_bytes;
          cap_meta_d   = packed_meta;
          idx_d        = 5'd0;
          ptr_d        = 5'd0;
          cnt_d        = 6'd0;
          err_acc_d    = 1'b0;
          work_d       = '0;
          state_d      = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        work_d = {work_q[DW-9:0], byte_val};
        if (meta_bit) begin
          ptr_d = 5'(ptr_q + 5'd1);
          cnt_d = 6'(cnt_q + 6'd1);
          if (CHECK_ZERO && (slot_sel == 8'h00)) err_acc_d = 1'b1;
        end
        idx_d = 5'(idx_q + 5'd1);
        if (idx_q == 5'd31) begin
          unpacked_d = work_d;
          nz_count_d = cnt_d;
          err_d      = err_acc_d;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      err_acc_q    <= 1'b0;
      work_q       <= '0;
      cap_packed_q <= '0;
      cap_meta_q   <= '0;
      unpacked_q   <= '0;
      nz_count_q   <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      err_acc_q    <= err_acc_d;
      work_q       <= work_d;
      cap_packed_q <= cap_packed_d;
      cap_meta_q   <= cap_meta_d;
      unpacked_q   <= unpacked_d;
      nz_count_q   <= nz_count_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign unpacked = unpacked_q;
  assign nz_count = nz_count_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_zero_byte_unpacker.sv
// Directed bench for zero_byte_unpacker; a second instance runs with zero-byte checking off.
module tb_zero_byte_unpacker;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] packed_bytes;
  logic [31:0]  packed_meta;
  logic [255:0] unpacked, unpacked_nc;
  logic [5:0]   nz_count, nz_count_nc;
  logic         busy, busy_nc, done, done_nc, err, err_nc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  zero_byte_unpacker #(.CHECK_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .packed_bytes(packed_bytes),
    .packed_meta(packed_meta), .unpacked(unpacked), .nz_count(nz_count),
    .busy(busy), .done(done), .err(err)
  );

  zero_byte_unpacker #(.CHECK_ZERO(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .start(start), .packed_bytes(packed_bytes),
    .packed_meta(packed_meta), .unpacked(unpacked_nc), .nz_count(nz_count_nc),
    .busy(busy_nc), .done(done_nc), .err(err_nc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] m, input logic [255:0] p);
    packed_meta  = m;
    packed_bytes = p;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Edges after the capture edge until done is seen; 40 means it never came.
  task automatic wait_done(output int n);
    n = 40;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; packed_bytes = '0; packed_meta = '0;
    tick(); tick();
    reset = 1'b0;
    n_vec++; if (unpacked !== 256'h0) begin n_err++; $display("FAIL reset_unpacked got %h exp 0", unpacked); end
    n_vec++; if (nz_count !== 6'd0) begin n_err++; $display("FAIL reset_nz got %0d exp 0", nz_count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_all_zero();
    int n;
    start_job(32'h0000_0000, {8{32'hDEAD_BEEF}});
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_busy got %b exp 1", busy); end
    wait_done(n);
    n_vec++; if (n !== 32) begin n_err++; $display("FAIL zero_latency got %0d exp 32", n); end
    n_vec++; if (unpacked !== 256'h0) begin n_err++; $display("FAIL zero_unpacked got %h exp 0", unpacked); end
    n_vec++; if (nz_count !== 6'd0) begin n_err++; $display("FAIL zero_nz got %0d exp 0", nz_count); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL zero_err got %b exp 0", err); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_busy_done got %b exp 1", busy); end
    tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_pulse got %b exp 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_zero_flag();
    int n;
    logic [255:0] p;
    p = {8'h00, {31{8'hFF}}};
    start_job(32'h4000_0000, p);
    wait_done(n);
    n_vec++; if (n !== 32) begin n_err++; $display("FAIL zflag_latency got %0d exp 32", n); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL zflag_err got %b exp 1", err); end
    n_vec++; if (err_nc !== 1'b0) begin n_err++; $display("FAIL zflag_err_nocheck got %b exp 0", err_nc); end
    n_vec++; if (nz_count !== 6'd1) begin n_err++; $display("FAIL zflag_nz got %0d exp 1", nz_count); end
    n_vec++; if (nz_count_nc !== 6'd1) begin n_err++; $display("FAIL zflag_nz_nocheck got %0d exp 1", nz_count_nc); end
    n_vec++; if (unpacked !== 256'h0) begin n_err++; $display("FAIL zflag_unpacked got %h exp 0", unpacked); end
    tick();
  endtask

  task automatic test_sparse();
    int n;
    logic [255:0] exp_u;
    exp_u = {8'hAA, 240'h0, 8'h55};
    start_job(32'h8000_0001, {8'hAA, 8'h55, {30{8'hFF}}});
    packed_bytes = {8'h11, 8'h22, {30{8'h33}}};
    packed_meta  = 32'hFFFF_FFFF;
    wait_done(n);
    n_vec++; if (n !== 32) begin n_err++; $display("FAIL sparse_latency got %0d exp 32", n); end
    n_vec++; if (unpacked !== exp_u) begin n_err++; $display("FAIL sparse_unpacked got %h exp %h", unpacked, exp_u); end
    n_vec++; if (nz_count !== 6'd2) begin n_err++; $display("FAIL sparse_nz got %0d exp 2", nz_count); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL sparse_err got %b exp 0", err); end
    repeat (5) tick();
    n_vec++; if (unpacked !== exp_u) begin n_err++; $display("FAIL sparse_hold got %h exp %h", unpacked, exp_u); end
    n_vec++; if (nz_count !== 6'd2) begin n_err++; $display("FAIL sparse_hold_nz got %0d exp 2", nz_count); end
  endtask

  task automatic test_reset_abort();
    int n;
    int seen;
    logic [255:0] exp_u;
    start_job(32'hFFFF_FFFF, {32{8'h77}});
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (unpacked !== 256'h0) begin n_err++; $display("FAIL abort_unpacked got %h exp 0", unpacked); end
    n_vec++; if (nz_count !== 6'd0) begin n_err++; $display("FAIL abort_nz got %0d exp 0", nz_count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b exp 0", busy); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_done got %0d exp 0", seen); end
    n_vec++; if (unpacked !== 256'h0) begin n_err++; $display("FAIL abort_stays_clear got %h exp 0", unpacked); end
    exp_u = {8'h12, 240'h0, 8'h34};
    start_job(32'h8000_0001, {8'h12, 8'h34, {30{8'hFF}}});
    wait_done(n);
    n_vec++; if (n !== 32) begin n_err++; $display("FAIL abort_job2_latency got %0d exp 32", n); end
    n_vec++; if (unpacked !== exp_u) begin n_err++; $display("FAIL abort_job2_unpacked got %h exp %h", unpacked, exp_u); end
    n_vec++; if (nz_count !== 6'd2) begin n_err++; $display("FAIL abort_job2_nz got %0d exp 2", nz_count); end
    tick();
  endtask

  task automatic test_all_ones();
    int n;
    logic [255:0] p;
    for (int i = 0; i < 32; i++) p[255 - 8*i -: 8] = 8'(i + 1);
    start_job(32'hFFFF_FFFF, p);
    wait_done(n);
    n_vec++; if (n !== 32) begin n_err++; $display("FAIL ones_latency got %0d exp 32", n); end
    n_vec++; if (unpacked !== p) begin n_err++; $display("FAIL ones_unpacked got %h exp %h", unpacked, p); end
    n_vec++; if (nz_count !== 6'd32) begin n_err++; $display("FAIL ones_nz got %0d exp 32", nz_count); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ones_err got %b exp 0", err); end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [255:0] hist [102];
    logic exp_done;
    for (int c = 0; c < 102; c++) begin
      hist[c] = {8{$urandom()}};
      packed_bytes = hist[c];
      packed_meta  = 32'hFFFF_FFFF;
      start        = (c < 100);
      tick();
      exp_done = ((c % 34) == 32);
      n_vec++; if (done !== exp_done) begin n_err++; $display("FAIL b2b_done cycle %0d got %b exp %b", c, done, exp_done); end
      if (exp_done) begin
        n_vec++;
        if (unpacked !== hist[c - 32]) begin
          n_err++; $display("FAIL b2b_unpacked cycle %0d got %h exp %h", c, unpacked, hist[c - 32]);
        end
      end
    end
    start = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_zero_flag();
    test_sparse();
    test_reset_abort();
    test_all_ones();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
